// File: rtl/uart_bus_bridge_pkg.sv
// Shared register map, STATUS layout and TX launcher state encoding for the
// UART bus bridge and the CPU-side address decoder.
package uart_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_DIV_LO = 2'd2,
    ADDR_DIV_HI = 2'd3
  } reg_addr_e;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_TX_OVF   = 4;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_WAIT   = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic tx_ovf;
    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;
  } status_t;

  function automatic logic [7:0] pack_status(input status_t s);
    pack_status = {3'b000, s.tx_ovf, s.rx_full, s.rx_empty, s.tx_full, s.tx_empty};
  endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// CPU register bus seen by the UART bridge: one-cycle read/write strobes,
// 2-bit register select and a combinational read-data return.
interface uart_bus_bridge_if;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_wr, bus_rd,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_wr, bus_rd,
    output bus_rdata
  );
endinterface

// File: rtl/uart_bus_bridge_byte_fifo.sv
// Byte-wide FIFO with power-of-two depth; a push while full is accepted when
// a pop happens in the same cycle, so a full FIFO can stream through.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == CNT_ZERO);
  assign full      = (count_r == CNT_FULL);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Register-mapped bridge between a CPU bus and a UART core: TX/RX byte FIFOs,
// a one-shot TX launcher, RX acknowledge with backpressure, and the divider.
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [11:0] DIV_RESET  = 12'd103
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_bus_bridge_if.slave     bus,
  output logic [11:0]          divider,
  output logic [7:0]           data_tx,
  output logic                 have_data_tx,
  input  logic                 transmitting,
  input  logic [7:0]           data_rx,
  input  logic                 have_data_rx,
  output logic                 data_rx_ack,
  output logic                 irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          tx_push_s;
  logic          tx_pop_s;
  logic          tx_full_s;
  logic          tx_empty_s;
  logic [7:0]    tx_head_s;
  logic [CW-1:0] tx_count_s;
  logic          rx_pop_s;
  logic          rx_full_s;
  logic          rx_empty_s;
  logic [7:0]    rx_head_s;
  logic [CW-1:0] rx_count_s;
  logic          unused_count_s;

  logic          tx_ovf_r;
  logic          ack_d_r;
  logic [11:0]   divider_r;
  tx_state_e     state_r;
  logic [7:0]    data_tx_r;
  logic          have_data_tx_r;
  status_t       status_s;

  assign tx_push_s      = bus.bus_wr && (bus.bus_addr == ADDR_DATA);
  assign rx_pop_s       = bus.bus_rd && (bus.bus_addr == ADDR_DATA);
  assign unused_count_s = ^{tx_count_s, rx_count_s};

  // ack_d blocks a second ack while the core is still clearing have_data_rx.
  assign data_rx_ack  = have_data_rx && !rx_full_s && !ack_d_r;
  assign irq          = !rx_empty_s;
  assign divider      = divider_r;
  assign data_tx      = data_tx_r;
  assign have_data_tx = have_data_tx_r;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .din   (bus.bus_wdata),
    .dout  (tx_head_s),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_rx_ack),
    .pop   (rx_pop_s),
    .din   (data_rx),
    .dout  (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  // Launcher pops the TX head only from IDLE with the core idle.
  always_comb begin
    tx_pop_s = 1'b0;
    if ((state_r == TX_IDLE) && !tx_empty_s && !transmitting) begin
      tx_pop_s = 1'b1;
    end else begin
      tx_pop_s = 1'b0;
    end
  end

  // Sticky TX overflow: a push into a full FIFO with no concurrent pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ovf_r <= 1'b0;
    end else if (bus.bus_wr && (bus.bus_addr == ADDR_STATUS)) begin
      tx_ovf_r <= 1'b0;
    end else if (tx_push_s && tx_full_s && !tx_pop_s) begin
      tx_ovf_r <= 1'b1;
    end
  end

  // Registered copy of the RX acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_d_r <= 1'b0;
    end else begin
      ack_d_r <= data_rx_ack;
    end
  end

  // Divider registers apply immediately, even mid-transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divider_r <= DIV_RESET;
    end else if (bus.bus_wr && (bus.bus_addr == ADDR_DIV_LO)) begin
      divider_r[7:0] <= bus.bus_wdata;
    end else if (bus.bus_wr && (bus.bus_addr == ADDR_DIV_HI)) begin
      divider_r[11:8] <= bus.bus_wdata[3:0];
    end
  end

  // TX launcher: one-cycle have_data_tx in LAUNCH, then wait for core idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= TX_IDLE;
      data_tx_r      <= 8'h00;
      have_data_tx_r <= 1'b0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          if (tx_pop_s) begin
            state_r        <= TX_LAUNCH;
            data_tx_r      <= tx_head_s;
            have_data_tx_r <= 1'b1;
          end else begin
            have_data_tx_r <= 1'b0;
          end
        end
        TX_LAUNCH: begin
          state_r        <= TX_WAIT;
          have_data_tx_r <= 1'b0;
        end
        TX_WAIT: begin
          have_data_tx_r <= 1'b0;
          if (!transmitting) begin
            state_r <= TX_IDLE;
          end
        end
        default: begin
          state_r        <= TX_IDLE;
          have_data_tx_r <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    status_s.tx_ovf   = tx_ovf_r;
    status_s.rx_full  = rx_full_s;
    status_s.rx_empty = rx_empty_s;
    status_s.tx_full  = tx_full_s;
    status_s.tx_empty = tx_empty_s;
  end

  // Read mux; an empty RX FIFO reads as zero.
  always_comb begin
    bus.bus_rdata = 8'h00;
    case (bus.bus_addr)
      ADDR_DATA: begin
        if (rx_empty_s) begin
          bus.bus_rdata = 8'h00;
        end else begin
          bus.bus_rdata = rx_head_s;
        end
      end
      ADDR_STATUS: bus.bus_rdata = pack_status(status_s);
      ADDR_DIV_LO: bus.bus_rdata = divider_r[7:0];
      ADDR_DIV_HI: bus.bus_rdata = {4'b0000, divider_r[11:8]};
      default:     bus.bus_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: register table plus hand-written TX/RX
// sequences against small behavioural models of the UART core.
module tb_uart_bus_bridge;
  import uart_bus_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] divider;
  logic [7:0]  data_tx;
  logic        have_data_tx;
  logic        transmitting;
  logic [7:0]  data_rx;
  logic        have_data_rx;
  logic        data_rx_ack;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  uart_bus_bridge_if bus();

  uart_bus_bridge #(.FIFO_DEPTH(4), .DIV_RESET(12'd103)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .divider      (divider),
    .data_tx      (data_tx),
    .have_data_tx (have_data_tx),
    .transmitting (transmitting),
    .data_rx      (data_rx),
    .have_data_rx (have_data_rx),
    .data_rx_ack  (data_rx_ack),
    .irq          (irq)
  );

  // TX core model: 10-cycle busy period per launched byte.
  logic       hold_busy = 1'b0;
  logic       tx_busy_r = 1'b0;
  int         tx_busy_cnt = 0;
  logic [7:0] tx_log [0:15];
  int         tx_log_cyc [0:15];
  int         tx_log_n = 0;
  int         tx_overlap = 0;
  int         tx_double = 0;
  logic       prev_have_r = 1'b0;

  assign transmitting = tx_busy_r | hold_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_have_r <= have_data_tx;
    if (!rst_n) begin
      tx_busy_cnt <= 0;
      tx_busy_r   <= 1'b0;
      tx_log_n    <= 0;
      tx_overlap  <= 0;
      tx_double   <= 0;
    end else begin
      if (have_data_tx && prev_have_r) tx_double <= tx_double + 1;
      if (have_data_tx) begin
        if (transmitting) tx_overlap <= tx_overlap + 1;
        if (tx_log_n < 16) begin
          tx_log[tx_log_n]     <= data_tx;
          tx_log_cyc[tx_log_n] <= cyc;
        end
        tx_log_n    <= tx_log_n + 1;
        tx_busy_cnt <= 10;
        tx_busy_r   <= 1'b1;
      end else if (tx_busy_cnt > 1) begin
        tx_busy_cnt <= tx_busy_cnt - 1;
      end else begin
        tx_busy_cnt <= 0;
        tx_busy_r   <= 1'b0;
      end
    end
  end

  // RX core model: presents rx_src[rx_sent] while rx_sent < rx_req.
  logic [7:0] rx_src [0:7];
  int         rx_req = 0;
  int         rx_sent = 0;
  int         rx_double = 0;
  logic       prev_ack_r = 1'b0;

  assign have_data_rx = (rx_sent < rx_req);
  assign data_rx      = rx_src[rx_sent[2:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      rx_sent    <= 0;
      rx_double  <= 0;
      prev_ack_r <= 1'b0;
    end else begin
      prev_ack_r <= data_rx_ack;
      if (data_rx_ack) rx_sent <= rx_sent + 1;
      if (data_rx_ack && prev_ack_r) rx_double <= rx_double + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.bus_addr  = 2'd0;
    bus.bus_wdata = 8'h00;
    bus.bus_wr    = 1'b0;
    bus.bus_rd    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    hold_busy = 1'b0;
    rx_req    = 0;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.bus_addr  = addr;
    bus.bus_wdata = data;
    bus.bus_wr    = 1'b1;
    @(posedge clk);
    #1;
    bus.bus_wr = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] addr, output logic [7:0] rdata);
    @(negedge clk);
    bus.bus_addr = addr;
    bus.bus_rd   = 1'b1;
    #1;
    rdata = bus.bus_rdata;
    @(posedge clk);
    #1;
    bus.bus_rd = 1'b0;
  endtask

  task automatic read_check(input string nm, input logic [1:0] addr, input logic [7:0] exp);
    logic [7:0] rd;
    do_read(addr, rd);
    check(nm, {24'h0, rd}, {24'h0, exp});
  endtask

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    vecs[0] = '{1'b0, ADDR_DIV_LO, 8'h00, 8'h67};
    vecs[1] = '{1'b0, ADDR_DIV_HI, 8'h00, 8'h00};
    vecs[2] = '{1'b0, ADDR_STATUS, 8'h00, 8'h05};
    vecs[3] = '{1'b0, ADDR_DATA,   8'h00, 8'h00};
    vecs[4] = '{1'b1, ADDR_DIV_HI, 8'h1F, 8'h00};
    vecs[5] = '{1'b1, ADDR_DIV_LO, 8'h34, 8'h00};
    vecs[6] = '{1'b0, ADDR_DIV_HI, 8'h00, 8'h0F};
    vecs[7] = '{1'b0, ADDR_DIV_LO, 8'h00, 8'h34};
    vecs[8] = '{1'b1, ADDR_STATUS, 8'hFF, 8'h00};
    vecs[9] = '{1'b0, ADDR_STATUS, 8'h00, 8'h05};
    for (int i = 0; i < 8; i++) rx_src[i] = 8'h00;
    bus_idle();

    // Reset values.
    do_reset();
    #1;
    check("rst_irq",     {31'h0, irq},          32'h0);
    check("rst_have_tx", {31'h0, have_data_tx}, 32'h0);
    check("rst_ack",     {31'h0, data_rx_ack},  32'h0);
    check("rst_data_tx", {24'h0, data_tx},      32'h0);
    check("rst_divider", {20'h0, divider},      32'h067);

    // Register table.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        do_read(vecs[i].addr, rd);
        check($sformatf("vec%0d", i), {24'h0, rd}, {24'h0, vecs[i].exp});
      end
    end
    check("divider_f34", {20'h0, divider}, 32'hF34);

    // Two bytes through a 10-cycle busy core.
    do_reset();
    do_write(ADDR_DATA, 8'h41);
    do_write(ADDR_DATA, 8'h42);
    repeat (40) @(posedge clk);
    #1;
    check("tx2_count",   tx_log_n,   32'd2);
    check("tx2_byte0",   {24'h0, tx_log[0]}, 32'h41);
    check("tx2_byte1",   {24'h0, tx_log[1]}, 32'h42);
    check("tx2_double",  tx_double,  32'd0);
    check("tx2_overlap", tx_overlap, 32'd0);
    check("tx2_gap",     {31'h0, (tx_log_cyc[1] - tx_log_cyc[0]) >= 11}, 32'h1);
    read_check("tx2_status", ADDR_STATUS, 8'h05);

    // TX overflow while the core is held busy.
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) do_write(ADDR_DATA, 8'hA0 + 8'(i));
    read_check("ovf_status", ADDR_STATUS, 8'h16);
    do_write(ADDR_STATUS, 8'h00);
    read_check("ovf_clear", ADDR_STATUS, 8'h06);
    check("ovf_no_launch", tx_log_n, 32'd0);
    @(negedge clk);
    hold_busy = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("ovf_count", tx_log_n, 32'd4);
    check("ovf_first", {24'h0, tx_log[0]}, 32'hA0);
    check("ovf_last",  {24'h0, tx_log[3]}, 32'hA3);
    check("ovf_overlap", tx_overlap, 32'd0);

    // Single RX byte.
    do_reset();
    @(negedge clk);
    rx_src[0] = 8'h5A;
    rx_req = 1;
    #1;
    check("rx1_ack",     {31'h0, data_rx_ack}, 32'h1);
    check("rx1_irq_pre", {31'h0, irq},         32'h0);
    @(negedge clk);
    #1;
    check("rx1_ack_off", {31'h0, data_rx_ack}, 32'h0);
    check("rx1_irq",     {31'h0, irq},         32'h1);
    check("rx1_sent",    rx_sent,              32'd1);
    read_check("rx1_data", ADDR_DATA, 8'h5A);
    check("rx1_irq_clr", {31'h0, irq}, 32'h0);

    // RX backpressure with five bytes.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) rx_src[i] = 8'h10 + 8'(i);
    rx_req = 5;
    repeat (20) @(posedge clk);
    #1;
    check("bp_sent",    rx_sent,               32'd4);
    check("bp_have_rx", {31'h0, have_data_rx}, 32'h1);
    check("bp_irq",     {31'h0, irq},          32'h1);
    read_check("bp_status", ADDR_STATUS, 8'h09);
    read_check("bp_data0",  ADDR_DATA,   8'h10);
    repeat (2) @(posedge clk);
    #1;
    check("bp_sent5", rx_sent, 32'd5);
    for (int i = 1; i < 5; i++) begin
      read_check($sformatf("bp_data%0d", i), ADDR_DATA, 8'h10 + 8'(i));
    end
    read_check("bp_status_end", ADDR_STATUS, 8'h05);
    check("bp_irq_end", {31'h0, irq},  32'h0);
    check("bp_double",  rx_double,     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
